// File: rtl/cpu_decode_buffered_pkg.sv
// Shared decode-stage types: fetch/decode beat layouts, operand-select codes,
// opcode constants and the ALU/memory/op lookup tables used by the decoder.
package cpu_decode_buffered_pkg;

  // Pointer width for a FIFO of the given depth (at least one bit).
  function automatic int fifo_ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  localparam int DECODE_DEPTH = 2;
  localparam int DECODE_PTR_W = fifo_ptr_w(DECODE_DEPTH);
  typedef logic [DECODE_PTR_W-1:0] decode_fifo_ptr_t;

  // Operand-select codes for the execute stage A/B muxes.
  localparam logic [1:0] OPSEL_RS   = 2'd0;
  localparam logic [1:0] OPSEL_IMM  = 2'd1;
  localparam logic [1:0] OPSEL_PC   = 2'd2;
  localparam logic [1:0] OPSEL_ZERO = 2'd3;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_SLL   = 4'd2,
    ALU_SLT   = 4'd3,
    ALU_SLTU  = 4'd4,
    ALU_XOR   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_OR    = 4'd8,
    ALU_AND   = 4'd9,
    ALU_PASSB = 4'd10
  } alu_op_e;

  typedef enum logic [1:0] {
    MEM_NONE  = 2'd0,
    MEM_LOAD  = 2'd1,
    MEM_STORE = 2'd2
  } mem_op_e;

  typedef enum logic [2:0] {
    OP_ALU     = 3'd0,
    OP_LOAD    = 3'd1,
    OP_STORE   = 3'd2,
    OP_BRANCH  = 3'd3,
    OP_JAL     = 3'd4,
    OP_JALR    = 3'd5,
    OP_CSR     = 3'd6,
    OP_ILLEGAL = 3'd7
  } op_class_e;

  typedef struct packed {
    logic        strobe;
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_data_t;

  typedef struct packed {
    logic        strobe;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rs3;
    logic [2:0]  have_rs;
    logic        have_rd;
    alu_op_e     alu_op;
    mem_op_e     mem_op;
    logic [2:0]  mem_size;
    op_class_e   op;
    logic [1:0]  sel_a;
    logic [1:0]  sel_b;
    logic [2:0]  funct3;
  } decode_data_t;

  // ALU operation table; funct7 bit 5 selects SUB (register form only) and SRA.
  function automatic alu_op_e alu_table(input logic [6:0] opcode, input logic [2:0] f3,
                                        input logic f7b5);
    alu_op_e r;
    case (opcode)
      OPC_OP, OPC_OPIMM: begin
        case (f3)
          3'b000:  r = (opcode == OPC_OP && f7b5) ? ALU_SUB : ALU_ADD;
          3'b001:  r = ALU_SLL;
          3'b010:  r = ALU_SLT;
          3'b011:  r = ALU_SLTU;
          3'b100:  r = ALU_XOR;
          3'b101:  r = f7b5 ? ALU_SRA : ALU_SRL;
          3'b110:  r = ALU_OR;
          3'b111:  r = ALU_AND;
          default: r = ALU_ADD;
        endcase
      end
      OPC_LUI:  r = ALU_PASSB;
      default:  r = ALU_ADD;
    endcase
    return r;
  endfunction

  // Memory access table.
  function automatic mem_op_e mem_table(input logic [6:0] opcode);
    case (opcode)
      OPC_LOAD:  return MEM_LOAD;
      OPC_STORE: return MEM_STORE;
      default:   return MEM_NONE;
    endcase
  endfunction

  // Instruction class table.
  function automatic op_class_e op_table(input logic [6:0] opcode);
    case (opcode)
      OPC_OP, OPC_OPIMM, OPC_LUI, OPC_AUIPC: return OP_ALU;
      OPC_LOAD:   return OP_LOAD;
      OPC_STORE:  return OP_STORE;
      OPC_BRANCH: return OP_BRANCH;
      OPC_JAL:    return OP_JAL;
      OPC_JALR:   return OP_JALR;
      OPC_SYSTEM: return OP_CSR;
      default:    return OP_ILLEGAL;
    endcase
  endfunction

  // Operand A source.
  function automatic logic [1:0] sel_a_table(input logic [6:0] opcode);
    case (opcode)
      OPC_OP, OPC_OPIMM, OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_JALR, OPC_SYSTEM: return OPSEL_RS;
      OPC_JAL, OPC_AUIPC: return OPSEL_PC;
      default:            return OPSEL_ZERO;
    endcase
  endfunction

  // Operand B source.
  function automatic logic [1:0] sel_b_table(input logic [6:0] opcode);
    case (opcode)
      OPC_OP, OPC_BRANCH: return OPSEL_RS;
      OPC_OPIMM, OPC_LOAD, OPC_STORE, OPC_JAL, OPC_JALR, OPC_LUI, OPC_AUIPC, OPC_SYSTEM:
        return OPSEL_IMM;
      default:            return OPSEL_ZERO;
    endcase
  endfunction

endpackage

// File: rtl/cpu_decode_buffered_if.sv
// Fetch/execute-facing bus of the buffered decode stage.
interface cpu_decode_buffered_if #(
  parameter int DEPTH = 2
);
  import cpu_decode_buffered_pkg::*;

  localparam int COUNT_W = $clog2(DEPTH + 1);

  logic               i_flush;
  fetch_data_t        i_data;
  logic               o_busy;
  decode_data_t       o_data;
  logic               i_ready;
  logic               o_fault;
  logic [31:0]        o_fault_pc;
  logic [COUNT_W-1:0] o_count;

  modport slave (
    input  i_flush, i_data, i_ready,
    output o_busy, o_data, o_fault, o_fault_pc, o_count
  );

  modport master (
    output i_flush, i_data, i_ready,
    input  o_busy, o_data, o_fault, o_fault_pc, o_count
  );
endinterface

// File: rtl/cpu_decode_fifo.sv
// Generic DEPTH-entry FIFO with a registered head output. The head register
// always holds the oldest entry (or all-zero when empty), so it stays stable
// while the consumer is not ready.
module cpu_decode_fifo
  import cpu_decode_buffered_pkg::*;
#(
  parameter int  DEPTH = 2,
  parameter type T     = decode_data_t
) (
  input  logic                         i_clock,
  input  logic                         i_reset,
  input  logic                         push_i,
  input  T                             data_in_i,
  input  logic                         pop_i,
  input  logic                         flush_i,
  output T                             head_o,
  output logic                         valid_o,
  output logic                         full_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);
  localparam int COUNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W   = fifo_ptr_w(DEPTH);

  typedef logic [PTR_W-1:0] ptr_t;

  T                   mem_q [DEPTH];
  T                   head_q, head_d;
  logic               valid_q, valid_d;
  ptr_t               rd_q, rd_d, wr_q, wr_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic               push_s, pop_s, full_s;

  function automatic ptr_t next_ptr(input ptr_t p);
    if (p == ptr_t'(DEPTH - 1)) begin
      return '0;
    end else begin
      return p + ptr_t'(1);
    end
  endfunction

  assign full_s = (count_q == COUNT_W'(DEPTH));
  assign push_s = push_i & ~full_s;
  assign pop_s  = pop_i & valid_q;

  // Next pointers, occupancy and head; a flush empties everything at once.
  always_comb begin
    rd_d    = rd_q;
    wr_d    = wr_q;
    count_d = count_q;
    head_d  = '0;
    valid_d = 1'b0;
    if (flush_i) begin
      rd_d    = '0;
      wr_d    = '0;
      count_d = '0;
    end else begin
      wr_d    = push_s ? next_ptr(wr_q) : wr_q;
      rd_d    = pop_s ? next_ptr(rd_q) : rd_q;
      count_d = count_q + COUNT_W'(push_s) - COUNT_W'(pop_s);
      if (count_d != '0) begin
        valid_d = 1'b1;
        // The entry being written this cycle becomes head when it is the next to read.
        head_d  = (push_s && (wr_q == rd_d)) ? data_in_i : mem_q[rd_d];
      end else begin
        valid_d = 1'b0;
      end
    end
  end

  // Entry storage; only control state needs a reset.
  always_ff @(posedge i_clock) begin
    if (push_s && !flush_i) begin
      mem_q[wr_q] <= data_in_i;
    end
  end

  // Pointer, occupancy and head registers.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
      head_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      count_q <= count_d;
      head_q  <= head_d;
      valid_q <= valid_d;
    end
  end

  assign head_o  = head_q;
  assign valid_o = valid_q;
  assign full_o  = full_s;
  assign count_o = count_q;
endmodule

// File: rtl/cpu_decode_buffered.sv
// Buffered decode stage: decodes each fetched beat, queues legal beats for
// execute, signals busy to fetch and captures the first illegal instruction.
module cpu_decode_buffered
  import cpu_decode_buffered_pkg::*;
#(
  parameter int DEPTH        = DECODE_DEPTH,
  parameter int FAULT_ENABLE = 1
) (
  input logic                  i_clock,
  input logic                  i_reset,
  cpu_decode_buffered_if.slave bus
);
  localparam int COUNT_W = $clog2(DEPTH + 1);

  logic [31:0]        instr_s;
  logic [6:0]         opcode_s;
  logic [2:0]         funct3_s;
  logic               fmt_b_s, fmt_i_s, fmt_j_s, fmt_s_s, fmt_u_s, fmt_r_s, fmt_csr_s;
  logic               any_fmt_s, illegal_s;
  logic               have_rs1_s, have_rs2_s, have_rs3_s, have_rd_s;
  decode_data_t       dec_s, head_s;
  logic               push_s, pop_s, fifo_valid_s, fifo_full_s;
  logic [COUNT_W-1:0] count_s;
  logic               fault_q, fault_d;
  logic [31:0]        fault_pc_q, fault_pc_d;

  assign instr_s  = bus.i_data.instr;
  assign opcode_s = instr_s[6:0];
  assign funct3_s = instr_s[14:12];

  assign fmt_b_s   = (opcode_s == OPC_BRANCH);
  assign fmt_i_s   = (opcode_s == OPC_OPIMM) | (opcode_s == OPC_LOAD) | (opcode_s == OPC_JALR);
  assign fmt_j_s   = (opcode_s == OPC_JAL);
  assign fmt_s_s   = (opcode_s == OPC_STORE);
  assign fmt_u_s   = (opcode_s == OPC_LUI) | (opcode_s == OPC_AUIPC);
  assign fmt_r_s   = (opcode_s == OPC_OP);
  // ECALL/EBREAK (funct3 = 0) are not supported and decode as illegal.
  assign fmt_csr_s = (opcode_s == OPC_SYSTEM) & (funct3_s != 3'b000);
  assign any_fmt_s = fmt_b_s | fmt_i_s | fmt_j_s | fmt_s_s | fmt_u_s | fmt_r_s | fmt_csr_s;
  assign illegal_s = (FAULT_ENABLE != 0) & ~any_fmt_s;

  // Register-use by format; CSR immediate forms (funct3[2]) read no rs1, no R4 format exists.
  assign have_rs1_s = fmt_b_s | fmt_i_s | fmt_s_s | fmt_r_s | (fmt_csr_s & ~funct3_s[2]);
  assign have_rs2_s = fmt_b_s | fmt_s_s | fmt_r_s;
  assign have_rs3_s = 1'b0;
  assign have_rd_s  = fmt_i_s | fmt_j_s | fmt_u_s | fmt_r_s | fmt_csr_s;

  // Combinational decode of the incoming beat into a queue entry.
  always_comb begin
    dec_s        = '0;
    dec_s.strobe = 1'b1;
    dec_s.pc     = bus.i_data.pc;
    if (fmt_b_s) begin
      dec_s.imm = {{19{instr_s[31]}}, instr_s[31], instr_s[7], instr_s[30:25], instr_s[11:8], 1'b0};
    end else if (fmt_i_s) begin
      dec_s.imm = {{20{instr_s[31]}}, instr_s[31:20]};
    end else if (fmt_j_s) begin
      dec_s.imm = {{11{instr_s[31]}}, instr_s[31], instr_s[19:12], instr_s[20], instr_s[30:21], 1'b0};
    end else if (fmt_s_s) begin
      dec_s.imm = {{20{instr_s[31]}}, instr_s[31:25], instr_s[11:7]};
    end else if (fmt_u_s) begin
      dec_s.imm = {instr_s[31:12], 12'h000};
    end else if (fmt_r_s) begin
      dec_s.imm = 32'h0000_0000;
    end else if (fmt_csr_s) begin
      dec_s.imm = {20'h00000, instr_s[31:20]};
    end else begin
      dec_s.imm = 32'h0000_0000;
    end
    dec_s.rs1      = instr_s[19:15];
    dec_s.rs2      = instr_s[24:20];
    dec_s.rs3      = instr_s[31:27];
    dec_s.rd       = have_rd_s ? instr_s[11:7] : 5'd0;
    dec_s.have_rd  = have_rd_s;
    dec_s.have_rs  = {have_rs3_s & (|instr_s[31:27]),
                      have_rs2_s & (|instr_s[24:20]),
                      have_rs1_s & (|instr_s[19:15])};
    dec_s.alu_op   = alu_table(opcode_s, funct3_s, instr_s[30]);
    dec_s.mem_op   = mem_table(opcode_s);
    dec_s.mem_size = (dec_s.mem_op != MEM_NONE) ? funct3_s : 3'd0;
    dec_s.op       = op_table(opcode_s);
    dec_s.sel_a    = sel_a_table(opcode_s);
    dec_s.sel_b    = sel_b_table(opcode_s);
    dec_s.funct3   = funct3_s;
  end

  // A full FIFO never accepts, even if it pops this cycle: busy is state-only.
  assign push_s = bus.i_data.strobe & ~fifo_full_s & ~bus.i_flush & ~illegal_s;
  assign pop_s  = fifo_valid_s & bus.i_ready;

  cpu_decode_fifo #(
    .DEPTH (DEPTH),
    .T     (decode_data_t)
  ) u_fifo (
    .i_clock   (i_clock),
    .i_reset   (i_reset),
    .push_i    (push_s),
    .data_in_i (dec_s),
    .pop_i     (pop_s),
    .flush_i   (bus.i_flush),
    .head_o    (head_s),
    .valid_o   (fifo_valid_s),
    .full_o    (fifo_full_s),
    .count_o   (count_s)
  );

  // Sticky fault: first accepted illegal beat wins; a flush clears it unconditionally.
  always_comb begin
    fault_d    = fault_q;
    fault_pc_d = fault_pc_q;
    if (bus.i_flush) begin
      fault_d    = 1'b0;
      fault_pc_d = 32'h0000_0000;
    end else if (bus.i_data.strobe && !fifo_full_s && illegal_s && !fault_q) begin
      fault_d    = 1'b1;
      fault_pc_d = bus.i_data.pc;
    end else begin
      fault_d    = fault_q;
      fault_pc_d = fault_pc_q;
    end
  end

  // Fault capture registers.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      fault_q    <= 1'b0;
      fault_pc_q <= 32'h0000_0000;
    end else begin
      fault_q    <= fault_d;
      fault_pc_q <= fault_pc_d;
    end
  end

  assign bus.o_busy     = fifo_full_s;
  assign bus.o_data     = head_s;
  assign bus.o_count    = count_s;
  assign bus.o_fault    = fault_q;
  assign bus.o_fault_pc = fault_pc_q;
endmodule
